// File: rtl/dsram_pkg.sv
// dsram_pkg: shared types, MMIO offsets and helpers for data_sram_resp.
// Exports: state_e {CLEAR, READY}, OFF_LED, OFF_COUNT, MMIO_HI_DEF, byte_merge().
package dsram_pkg;
  typedef enum logic {CLEAR, READY} state_e;
  localparam logic [15:0] OFF_LED = 16'hf000;
  localparam logic [15:0] OFF_COUNT = 16'he000;
  localparam logic [15:0] MMIO_HI_DEF = 16'h1faf;
  function automatic logic [31:0] byte_merge(input logic [31:0] old_w, input logic [31:0] new_w, input logic [3:0] wen);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i+:8] = wen[i] ? new_w[8*i+:8] : old_w[8*i+:8];
    return r;
  endfunction
endpackage

// File: rtl/dsram_bank.sv
// dsram_bank: 2^ADDR_W x 32 byte-enable synchronous RAM, read-first, 1-cycle registered read.
// Ports: clk; re_i read enable (rdata_o holds when low); wen_i byte write enables;
//        addr_i word index; wdata_i write data; rdata_o registered read data.
module dsram_bank #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              re_i,
  input  logic [3:0]        wen_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);
  logic [31:0] mem_q [2**ADDR_W];
  always_ff @(posedge clk) begin
    if (re_i) rdata_o <= mem_q[addr_i];
    for (int i = 0; i < 4; i++) if (wen_i[i]) mem_q[addr_i][8*i+:8] <= wdata_i[8*i+:8];
  end
endmodule

// File: rtl/data_sram_resp.sv
// data_sram_resp: data-side SRAM responder with RAM bank, LED and COUNT MMIO registers.
// Ports: clk, rst (sync, active-high); data_sram_en/wen/addr/wdata request; data_sram_rdata
//        registered read data (1-cycle latency, held when idle); init_done; led_out.
// Macro DSRAM_CLEAR_EN: when defined, a CLEAR state zeroes the RAM after reset before init_done.
module data_sram_resp
  import dsram_pkg::*;
#(
  parameter int          ADDR_W  = 12,
  parameter logic [15:0] MMIO_HI = MMIO_HI_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        init_done,
  output logic [15:0] led_out
);
  logic is_mmio, accept, ram_acc, led_wr, cnt_wr, ready, init_done_q, sel_mmio_q;
  logic [15:0] off, led_q, led_d;
  logic [31:0] count_q, count_d, mmio_rdata_q, mmio_rd, b_wdata, b_rdata;
  logic [ADDR_W-1:0] idx, b_addr;
  logic [3:0] b_wen;
  always_comb begin
    is_mmio = data_sram_addr[31:16] == MMIO_HI;
    off = data_sram_addr[15:0];
    idx = data_sram_addr[ADDR_W+1:2];
    accept = data_sram_en & init_done_q;
    ram_acc = accept & ~is_mmio;
    led_wr = accept & is_mmio & (off == OFF_LED) & |data_sram_wen[1:0];
    cnt_wr = accept & is_mmio & (off == OFF_COUNT) & |data_sram_wen;
    led_d = {data_sram_wen[1] ? data_sram_wdata[15:8] : led_q[15:8],
             data_sram_wen[0] ? data_sram_wdata[7:0] : led_q[7:0]};
    // A COUNT write replaces that cycle's increment.
    count_d = cnt_wr ? byte_merge(count_q, data_sram_wdata, data_sram_wen) : count_q + 32'd1;
    mmio_rd = off == OFF_LED ? {16'h0, led_q} : off == OFF_COUNT ? count_q : 32'h0;
  end
`ifdef DSRAM_CLEAR_EN
  state_e state_q;
  logic [ADDR_W-1:0] clr_idx_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      clr_idx_q <= '0;
    end else if (state_q == CLEAR) begin
      clr_idx_q <= clr_idx_q + ADDR_W'(1);
      state_q <= &clr_idx_q ? READY : CLEAR;
    end
  end
  // The bank write port is owned by the clear sweep until READY.
  always_comb begin
    ready = state_q == READY;
    b_wen = ready ? (ram_acc ? data_sram_wen : 4'h0) : 4'hf;
    b_addr = ready ? idx : clr_idx_q;
    b_wdata = ready ? data_sram_wdata : 32'h0;
  end
`else
  always_comb begin
    ready = 1'b1;
    b_wen = ram_acc ? data_sram_wen : 4'h0;
    b_addr = idx;
    b_wdata = data_sram_wdata;
  end
`endif
  dsram_bank #(.ADDR_W(ADDR_W)) u_bank (
    .clk     (clk),
    .re_i    (ram_acc),
    .wen_i   (b_wen),
    .addr_i  (b_addr),
    .wdata_i (b_wdata),
    .rdata_o (b_rdata)
  );
  // Reset selects the MMIO path with zero data so rdata reads 0 without resetting the bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      init_done_q <= 1'b0;
      led_q <= '0;
      count_q <= '0;
      sel_mmio_q <= 1'b1;
      mmio_rdata_q <= '0;
    end else begin
      init_done_q <= ready;
      count_q <= count_d;
      if (led_wr) led_q <= led_d;
      if (accept) sel_mmio_q <= is_mmio;
      if (accept & is_mmio) mmio_rdata_q <= mmio_rd;
    end
  end
  assign data_sram_rdata = sel_mmio_q ? mmio_rdata_q : b_rdata;
  assign init_done = init_done_q;
  assign led_out = led_q;
endmodule

// File: tb/tb_data_sram_resp.sv
// tb_data_sram_resp: scoreboard bench for data_sram_resp with directed vectors.
module tb_data_sram_resp;
  logic clk = 1'b0, rst = 1'b1, data_sram_en = 1'b0, init_done;
  logic [3:0] data_sram_wen = 4'h0;
  logic [31:0] data_sram_addr = 32'h0, data_sram_wdata = 32'h0, data_sram_rdata;
  logic [15:0] led_out;
  int n_cmp = 0, n_bad = 0;
  typedef struct {string nm; bit chk; logic [31:0] exp;} ent_t;
  ent_t sb[$];
`ifdef DSRAM_CLEAR_EN
  localparam int EXP_INIT = 17;
`else
  localparam int EXP_INIT = 1;
`endif
  data_sram_resp #(.ADDR_W(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .init_done       (init_done),
    .led_out         (led_out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask
  bit pending = 0, known = 1;
  logic [31:0] last_exp = 32'h0;
  always @(negedge clk) begin
    if (rst) begin
      pending = 0;
      known = 1;
      last_exp = 32'h0;
    end else begin
      if (pending) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_response: got %h expected no response", data_sram_rdata);
        end else begin
          ent_t e;
          e = sb.pop_front();
          if (e.chk) chk(e.nm, data_sram_rdata, e.exp);
          known = e.chk;
          last_exp = e.exp;
        end
      end else if (known) chk("hold", data_sram_rdata, last_exp);
      pending = data_sram_en && init_done;
    end
  end
  task automatic drive(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d,
                       input bit c, input logic [31:0] x, input string nm);
    ent_t t;
    @(posedge clk); #1;
    data_sram_en = e;
    data_sram_wen = w;
    data_sram_addr = a;
    data_sram_wdata = d;
    if (e) begin
      t.nm = nm;
      t.chk = c;
      t.exp = x;
      sb.push_back(t);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, "idle");
  endtask
  task automatic wait_init(input int exp_n);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!init_done && n < 200);
    chk("init_latency", 32'(n), 32'(exp_n));
  endtask
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    data_sram_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdata", data_sram_rdata, 32'h0);
    chk("rst_led", {16'h0, led_out}, 32'h0);
    chk("rst_init_done", {31'h0, init_done}, 32'h0);
    rst = 1'b0;
    wait_init(EXP_INIT);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
  initial begin
    do_reset();
    drive(1, 4'hf, 32'h10, 32'hdeadbeef, 0, 32'h0, "w_ram");
    drive(1, 4'h0, 32'h10, 32'h0, 1, 32'hdeadbeef, "raw_read");
    drive(1, 4'b0100, 32'h10, 32'h00aa0000, 1, 32'hdeadbeef, "lane_wr_readfirst");
    drive(1, 4'h0, 32'h10, 32'h0, 1, 32'hdeaabeef, "lane_merge");
    drive(1, 4'h0, 32'hff000051, 32'h0, 1, 32'hdeaabeef, "addr_alias");
    drive(1, 4'h0, 32'h10, 32'hffffffff, 1, 32'hdeaabeef, "wen0_read");
    drive(1, 4'h0, 32'h10, 32'h0, 1, 32'hdeaabeef, "wen0_nowrite");
    idle(2);
    drive(1, 4'hf, 32'h1fafe000, 32'hfffffffe, 0, 32'h0, "cnt_load");
    drive(1, 4'h0, 32'h1fafe000, 32'h0, 1, 32'hfffffffe, "cnt_n1");
    drive(1, 4'h0, 32'h1fafe000, 32'h0, 1, 32'hffffffff, "cnt_n2");
    drive(1, 4'h0, 32'h1fafe000, 32'h0, 1, 32'h00000000, "cnt_wrap");
    drive(1, 4'hf, 32'h1faff000, 32'h1234abcd, 1, 32'h0, "led_wr_old");
    drive(1, 4'h0, 32'h1faff000, 32'h0, 1, 32'h0000abcd, "led_rd");
    idle(1);
    chk("led_out", {16'h0, led_out}, 32'h0000abcd);
    drive(1, 4'b1100, 32'h1faff000, 32'hffff5555, 1, 32'h0000abcd, "led_hi_wr");
    drive(1, 4'b0001, 32'h1faff000, 32'h00000077, 1, 32'h0000abcd, "led_lo_wr");
    drive(1, 4'h0, 32'h1faff000, 32'h0, 1, 32'h0000ab77, "led_partial");
    idle(1);
    chk("led_out_partial", {16'h0, led_out}, 32'h0000ab77);
    drive(1, 4'h0, 32'h1faf0004, 32'h0, 1, 32'h0, "unmapped_rd");
    drive(1, 4'hf, 32'h1faf0004, 32'hffffffff, 1, 32'h0, "unmapped_wr");
    drive(1, 4'h0, 32'h1faf0004, 32'h0, 1, 32'h0, "unmapped_rd2");
    drive(1, 4'hf, 32'h20, 32'h11111111, 0, 32'h0, "w20");
    drive(1, 4'hf, 32'h20, 32'h22222222, 1, 32'h11111111, "rw_same_cycle");
    idle(5);
    drive(1, 4'h0, 32'h20, 32'h0, 1, 32'h22222222, "rd20");
    idle(2);
`ifdef DSRAM_CLEAR_EN
    begin
      int n = 0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      do begin
        @(posedge clk); #1;
        n++;
        data_sram_en = (n == 10);
        data_sram_wen = 4'hf;
        data_sram_addr = 32'h10;
        data_sram_wdata = 32'hcafef00d;
      end while (!init_done && n < 200);
      data_sram_en = 1'b0;
      chk("clear_restart_latency", 32'(n), 32'd17);
      chk("clear_led", {16'h0, led_out}, 32'h0);
      drive(1, 4'h0, 32'h10, 32'h0, 1, 32'h0, "clear_drop_rd");
      drive(1, 4'h0, 32'h20, 32'h0, 1, 32'h0, "clear_rd20");
      idle(2);
    end
`endif
    idle(3);
    chk("drain", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
